lcd_bus_driver: RTL and testbench

Bus-level driver for the HD44780-style character LCD. It accepts one command or data byte per start handshake from the LCD content sequencer (`iDATA`/`iRS`/`iStart` → `oDone`) and generates the timed RS/RW/EN/DATA waveform on the panel pins. It can optionally poll the busy flag after each write before reporting completion. It replaces fixed-delay pacing with a bounded, measurable handshake.

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_bus_driver.sv | 232 +++++++++++++++++++++++
 tb/tb_lcd_bus_driver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780-style LCD bus driver and
//               the content sequencer: bus-phase state encoding, default
//               timing constants and the instruction bytes used at bring-up.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Bus phase of the driver; write phases first, then the busy-read phases.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_SETUP = 3'd1,
        ST_W_EN    = 3'd2,
        ST_W_HOLD  = 3'd3,
        ST_R_SETUP = 3'd4,
        ST_R_EN    = 3'd5,
        ST_R_HOLD  = 3'd6,
        ST_DONE    = 3'd7
    } lcd_state_t;

    // Default phase timing in clock cycles.
    localparam int LCD_T_AS_DEF      = 4;
    localparam int LCD_T_PW_DEF      = 16;
    localparam int LCD_T_H_DEF       = 4;
    localparam int LCD_MAX_POLLS_DEF = 255;

    // Instruction bytes issued by the content sequencer.
    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_driver
// Description : Generates the timed RS/RW/EN/DATA waveform for one command or
//               data byte per start handshake, optionally polling the panel
//               busy flag before signalling completion.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_AS      = LCD_T_AS_DEF,
    parameter int T_PW      = LCD_T_PW_DEF,
    parameter int T_H       = LCD_T_H_DEF,
    parameter int BUSY_POLL = 1,
    parameter int MAX_POLLS = LCD_MAX_POLLS_DEF
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oErr,
    output logic       oBusy,
    output logic [7:0] LCD_DATA_O,
    input  logic [7:0] LCD_DATA_I,
    output logic       LCD_DATA_OE,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    localparam int CW = $clog2(lcd_max3(T_AS, T_PW, T_H) + 1);

    localparam logic [CW-1:0] c_AS_LAST   = CW'(T_AS - 1);
    localparam logic [CW-1:0] c_PW_LAST   = CW'(T_PW - 1);
    localparam logic [CW-1:0] c_H_LAST    = CW'(T_H - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [7:0]    c_MAX_POLLS = 8'(MAX_POLLS);

    lcd_state_t    r_state;
    lcd_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [7:0]    r_poll;
    logic [7:0]    w_poll_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          r_start_d;
    logic          r_bf;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          w_accept;
    logic          w_rs_lat;
    logic [7:0]    w_data_lat;
    logic          w_nxt_write;
    logic          w_nxt_read;

    // Output pins are registered from the next state so they are glitch-free.
    logic          r_en;
    logic          r_rw;
    logic          r_rs_pin;
    logic          r_oe;
    logic [7:0]    r_data_o;
    logic          r_done;
    logic          r_err_o;
    logic          r_busy;

    // Only the busy flag (bit 7) matters on a read; the address counter is ignored.
    logic          w_unused_di;
    assign w_unused_di = ^LCD_DATA_I[6:0];

    assign w_accept   = iStart & ~r_start_d & (r_state == ST_IDLE);
    assign w_cnt_inc  = r_cnt + c_CNT_ONE;
    assign w_rs_lat   = w_accept ? iRS : r_rs;
    assign w_data_lat = w_accept ? iDATA : r_data;

    assign w_nxt_write = (w_state_nxt == ST_W_SETUP) || (w_state_nxt == ST_W_EN) ||
                         (w_state_nxt == ST_W_HOLD);
    assign w_nxt_read  = (w_state_nxt == ST_R_SETUP) || (w_state_nxt == ST_R_EN) ||
                         (w_state_nxt == ST_R_HOLD);

    // State, phase counter, poll counter and error flag registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_poll  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_poll  <= w_poll_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic: each phase lasts its own cycle count, counter restarts at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_poll_nxt  = r_poll;
        w_err_nxt   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_W_SETUP;
                    w_cnt_nxt   = '0;
                    w_poll_nxt  = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_W_SETUP: begin
                if (r_cnt == c_AS_LAST) begin
                    w_state_nxt = ST_W_EN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_W_EN: begin
                if (r_cnt == c_PW_LAST) begin
                    w_state_nxt = ST_W_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_W_HOLD: begin
                if (r_cnt == c_H_LAST) begin
                    w_state_nxt = (BUSY_POLL != 0) ? ST_R_SETUP : ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_R_SETUP: begin
                if (r_cnt == c_AS_LAST) begin
                    w_state_nxt = ST_R_EN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_R_EN: begin
                if (r_cnt == c_PW_LAST) begin
                    w_state_nxt = ST_R_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_R_HOLD: begin
                if (r_cnt == c_H_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_bf) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_poll < c_MAX_POLLS) begin
                        w_state_nxt = ST_R_SETUP;
                        w_poll_nxt  = r_poll + 8'd1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Start edge detector, request latch and busy-flag sample at the end of R_EN.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_start_d <= 1'b0;
            r_data    <= '0;
            r_rs      <= 1'b0;
            r_bf      <= 1'b0;
        end else begin
            r_start_d <= iStart;
            r_data    <= w_data_lat;
            r_rs      <= w_rs_lat;
            if ((r_state == ST_R_EN) && (w_state_nxt == ST_R_HOLD)) begin
                r_bf <= LCD_DATA_I[7];
            end
        end
    end

    // Pin and handshake registers decoded from the state being entered.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_en     <= 1'b0;
            r_rw     <= 1'b0;
            r_rs_pin <= 1'b0;
            r_oe     <= 1'b0;
            r_data_o <= '0;
            r_done   <= 1'b0;
            r_err_o  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_en     <= (w_state_nxt == ST_W_EN) || (w_state_nxt == ST_R_EN);
            r_rw     <= w_nxt_read;
            r_rs_pin <= w_nxt_write & w_rs_lat;
            r_oe     <= w_nxt_write;
            r_data_o <= w_data_lat;
            r_done   <= (w_state_nxt == ST_DONE);
            r_err_o  <= (w_state_nxt == ST_DONE) & w_err_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign LCD_EN      = r_en;
    assign LCD_RW      = r_rw;
    assign LCD_RS      = r_rs_pin;
    assign LCD_DATA_OE = r_oe;
    assign LCD_DATA_O  = r_data_o;
    assign oDone       = r_done;
    assign oErr        = r_err_o;
    assign oBusy       = r_busy;

endmodule : lcd_bus_driver
`default_nettype wire

// File: tb/tb_lcd_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_driver
// Description : Directed self-checking bench. Three driver instances share the
//               request inputs: write-only, busy-poll with a panel model that
//               reports busy twice, and MAX_POLLS=3 with busy stuck high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_driver;
    import lcd_pkg::*;

    localparam int TAS = 2;
    localparam int TPW = 4;
    localparam int TH  = 2;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic [7:0] iDATA  = 8'h00;
    logic       iRS    = 1'b0;
    logic       iStart = 1'b0;

    always #5 iCLK = ~iCLK;

    logic       w_done [3];
    logic       w_err  [3];
    logic       w_busy [3];
    logic       w_oe   [3];
    logic       w_rs   [3];
    logic       w_rw   [3];
    logic       w_en   [3];
    logic [7:0] w_do   [3];
    logic [7:0] w_di   [3];

    // Panel-side monitor counters, stepped only by the monitor process.
    int   en_pulses [3];
    int   en_cyc    [3];
    int   rd_pulses [3];
    int   done_cnt  [3];
    int   rw_oe_viol[3];
    int   oe_en_viol[3];
    int   en_dn_viol[3];
    int   bad_run   [3];
    int   run_len   [3];
    bit   prev_en   [3];
    bit   prev_oe   [3];
    bit [7:0] last_wb[3];
    bit   last_rs   [3];

    // Bench-side bookkeeping, written only by the stimulus process.
    int   rd_base = 0;
    int   r_lat    [3];
    logic r_err_at [3];
    int   snap_done[3];
    int   snap_en  [3];
    int   snap_ecyc[3];
    int   snap_rd  [3];
    logic r_busy0;
    logic r_busy9;

    int   n_chk = 0;
    int   n_err = 0;

    // Busy model: first two reads of each transfer report BF=1, then BF=0.
    assign w_di[0] = 8'h00;
    assign w_di[1] = ((rd_pulses[1] - rd_base) <= 2) ? 8'h80 : 8'h00;
    assign w_di[2] = 8'h80;

    lcd_bus_driver #(.T_AS(TAS), .T_PW(TPW), .T_H(TH), .BUSY_POLL(0), .MAX_POLLS(255)) u_nopoll (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
        .oDone(w_done[0]), .oErr(w_err[0]), .oBusy(w_busy[0]),
        .LCD_DATA_O(w_do[0]), .LCD_DATA_I(w_di[0]), .LCD_DATA_OE(w_oe[0]),
        .LCD_RS(w_rs[0]), .LCD_RW(w_rw[0]), .LCD_EN(w_en[0])
    );

    lcd_bus_driver #(.T_AS(TAS), .T_PW(TPW), .T_H(TH), .BUSY_POLL(1), .MAX_POLLS(255)) u_poll (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
        .oDone(w_done[1]), .oErr(w_err[1]), .oBusy(w_busy[1]),
        .LCD_DATA_O(w_do[1]), .LCD_DATA_I(w_di[1]), .LCD_DATA_OE(w_oe[1]),
        .LCD_RS(w_rs[1]), .LCD_RW(w_rw[1]), .LCD_EN(w_en[1])
    );

    lcd_bus_driver #(.T_AS(TAS), .T_PW(TPW), .T_H(TH), .BUSY_POLL(1), .MAX_POLLS(3)) u_exh (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
        .oDone(w_done[2]), .oErr(w_err[2]), .oBusy(w_busy[2]),
        .LCD_DATA_O(w_do[2]), .LCD_DATA_I(w_di[2]), .LCD_DATA_OE(w_oe[2]),
        .LCD_RS(w_rs[2]), .LCD_RW(w_rw[2]), .LCD_EN(w_en[2])
    );

    // Pin monitor: pulse counts, EN width, and the OE/RW/EN ordering rules.
    always @(negedge iCLK) begin
        for (int k = 0; k < 3; k++) begin
            if (iRST_N) begin
                if (w_en[k] && !prev_en[k]) begin
                    en_pulses[k]++;
                    if (w_rw[k]) rd_pulses[k]++;
                end
                if (w_en[k]) en_cyc[k]++;
                if (w_oe[k] && w_rw[k]) rw_oe_viol[k]++;
                if ((w_oe[k] != prev_oe[k]) && (w_en[k] != prev_en[k])) oe_en_viol[k]++;
                if (w_en[k] && w_done[k]) en_dn_viol[k]++;
                if (w_en[k]) begin
                    run_len[k]++;
                end else begin
                    if (run_len[k] != 0 && run_len[k] != TPW) bad_run[k]++;
                    run_len[k] = 0;
                end
                if (w_en[k] && !w_rw[k]) begin
                    last_wb[k] = w_do[k];
                    last_rs[k] = w_rs[k];
                end
                if (w_done[k]) done_cnt[k]++;
            end else begin
                run_len[k] = 0;
            end
            prev_en[k] = w_en[k];
            prev_oe[k] = w_oe[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    // One request; i=0 is the cycle right after the accept edge. Latency is
    // the first i with oDone high, -1 if never seen within the window.
    task automatic run_xfer(input logic [7:0] d, input logic rs, input bit hold, input int glitch);
        for (int k = 0; k < 3; k++) begin
            r_lat[k]     = -1;
            r_err_at[k]  = 1'b0;
            snap_done[k] = done_cnt[k];
            snap_en[k]   = en_pulses[k];
            snap_ecyc[k] = en_cyc[k];
            snap_rd[k]   = rd_pulses[k];
        end
        rd_base = rd_pulses[1];
        iDATA   = d;
        iRS     = rs;
        iStart  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 0 && !hold) iStart = 1'b0;
            if (i == glitch) iStart = 1'b1;
            if (i == glitch + 1) iStart = 1'b0;
            if (i == 0) r_busy0 = w_busy[0];
            if (i == 9) r_busy9 = w_busy[0];
            for (int k = 0; k < 3; k++) begin
                if (r_lat[k] < 0 && w_done[k]) begin
                    r_lat[k]    = i;
                    r_err_at[k] = w_err[k];
                end
            end
        end
        iStart = 1'b0;
        tick();
        tick();
    endtask

    logic [7:0] cmds [5];

    initial begin
        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_pins%0d", k),
                32'({w_en[k], w_rw[k], w_rs[k], w_oe[k], w_done[k], w_err[k], w_busy[k], w_do[k]}),
                32'h0);
        end
        tick();
        tick();
        iRST_N = 1'b1;
        tick();
        tick();

        // Data write 0x41, RS=1 on all three instances
        run_xfer(8'h41, 1'b1, 1'b0, -5);
        chk("np_latency",   32'(r_lat[0]), 32'd8);
        chk("np_err",       32'(r_err_at[0]), 32'd0);
        chk("np_busy_acc",  32'(r_busy0), 32'd1);
        chk("np_busy_end",  32'(r_busy9), 32'd0);
        chk("np_en_pulses", 32'(en_pulses[0] - snap_en[0]), 32'd1);
        chk("np_en_cycles", 32'(en_cyc[0] - snap_ecyc[0]), 32'd4);
        chk("np_rd_pulses", 32'(rd_pulses[0] - snap_rd[0]), 32'd0);
        chk("np_byte",      32'(last_wb[0]), 32'h41);
        chk("np_rs",        32'(last_rs[0]), 32'd1);
        chk("poll_latency", 32'(r_lat[1]), 32'd32);
        chk("poll_reads",   32'(rd_pulses[1] - snap_rd[1]), 32'd3);
        chk("poll_err",     32'(r_err_at[1]), 32'd0);
        chk("poll_byte",    32'(last_wb[1]), 32'h41);
        chk("exh_latency",  32'(r_lat[2]), 32'd40);
        chk("exh_reads",    32'(rd_pulses[2] - snap_rd[2]), 32'd4);
        chk("exh_err",      32'(r_err_at[2]), 32'd1);
        chk("exh_dones",    32'(done_cnt[2] - snap_done[2]), 32'd1);

        // iStart held high through completion: one transfer only
        run_xfer(8'h55, 1'b1, 1'b1, -5);
        chk("hold_latency", 32'(r_lat[0]), 32'd8);
        chk("hold_np_done", 32'(done_cnt[0] - snap_done[0]), 32'd1);
        chk("hold_ex_done", 32'(done_cnt[2] - snap_done[2]), 32'd1);
        chk("hold_np_en",   32'(en_pulses[0] - snap_en[0]), 32'd1);

        // Extra rising edge during W_EN is ignored and not queued
        run_xfer(8'h66, 1'b0, 1'b0, 3);
        chk("glitch_latency", 32'(r_lat[0]), 32'd8);
        chk("glitch_np_done", 32'(done_cnt[0] - snap_done[0]), 32'd1);
        chk("glitch_pl_done", 32'(done_cnt[1] - snap_done[1]), 32'd1);
        chk("glitch_byte",    32'(last_wb[0]), 32'h66);

        // Bring-up instruction sequence, RS=0
        cmds[0] = LCD_CMD_FUNCSET;
        cmds[1] = LCD_CMD_DISPON;
        cmds[2] = LCD_CMD_CLEAR;
        cmds[3] = LCD_CMD_ENTRY;
        cmds[4] = LCD_CMD_LINE1;
        for (int j = 0; j < 5; j++) begin
            run_xfer(cmds[j], 1'b0, 1'b0, -5);
            chk($sformatf("cmd%0d_byte", j), 32'(last_wb[0]), 32'(cmds[j]));
            chk($sformatf("cmd%0d_rs", j),   32'(last_rs[0]), 32'd0);
        end

        // Reset asserted mid EN pulse aborts without oDone
        for (int k = 0; k < 3; k++) snap_done[k] = done_cnt[k];
        iDATA  = 8'hA5;
        iRS    = 1'b1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_en_before", 32'(w_en[0]), 32'd1);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("rst_en_async", 32'({w_en[0], w_en[1], w_en[2]}), 32'd0);
        tick();
        tick();
        iRST_N = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("rst_no_done", 32'(done_cnt[0] - snap_done[0]), 32'd0);
        run_xfer(8'h42, 1'b1, 1'b0, -5);
        chk("post_rst_latency", 32'(r_lat[0]), 32'd8);
        chk("post_rst_byte",    32'(last_wb[0]), 32'h42);
        chk("post_rst_poll",    32'(r_lat[1]), 32'd32);

        // Whole-run pin invariants
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("oe_with_rw%0d", k), 32'(rw_oe_viol[k]), 32'd0);
            chk($sformatf("oe_en_edge%0d", k), 32'(oe_en_viol[k]), 32'd0);
            chk($sformatf("en_in_done%0d", k), 32'(en_dn_viol[k]), 32'd0);
            chk($sformatf("en_width%0d", k),   32'(bad_run[k]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_lcd_bus_driver
`default_nettype wire
